damage_accumulator: RTL

Sequential combat resolver, run once per game tick. It scans all 16 friendly-unit and 16 enemy slots through an indexed read port, picks the frontmost live target on each side, and sums the attack of every attacker in range of that target. It sits directly upstream of the damage decoder and drives its select and total-damage inputs. Results are registered and held stable between ticks.

---
 rtl/damage_accumulator.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/damage_accumulator.sv
// rtl/damage_accumulator.sv - per-tick combat resolver: target search plus in-range attack summation
//
// Purpose:
//   On Start, scans the 16 friendly-unit slots and the 16 enemy slots twice
//   through one shared index. The first pass (FIND) picks the frontmost live
//   target on each side. The second pass (ACCUM) sums the attack of every
//   attacker that is in range of the opposing target. Results are registered
//   and held until the next tick completes.
//
// Ports:
//   Clk                : system clock, rising edge
//   Reset              : synchronous, active-high reset
//   Start              : tick request, only sampled in IDLE
//   scanIndex[3:0]     : slot index driven to both register files
//   unitAlive/unitPos[9:0]/unitAttack[7:0]    : unit[scanIndex] read data
//   enemyAlive/enemyPos[9:0]/enemyAttack[7:0] : enemy[scanIndex] read data
//   unitDamageSelect[4:0]  : friendly target (0-15 slot, 16 = friendly tower)
//   enemyDamageSelect[4:0] : enemy target (0-15 slot, 16 = enemy tower)
//   totalUnitDamage[11:0]  : friendly attack applied to enemyDamageSelect
//   totalEnemyDamage[11:0] : enemy attack applied to unitDamageSelect
//   Busy               : high while scanning (FIND and ACCUM)
//   Done               : one-cycle pulse when new results are on the outputs

module damage_accumulator #(
  parameter int unsigned UNIT_RANGE         = 40,
  parameter int unsigned ENEMY_RANGE        = 40,
  parameter int unsigned FRIENDLY_TOWER_POS = 20,
  parameter int unsigned ENEMY_TOWER_POS    = 620
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic [3:0]  scanIndex,
  input  logic        unitAlive,
  input  logic [9:0]  unitPos,
  input  logic [7:0]  unitAttack,
  input  logic        enemyAlive,
  input  logic [9:0]  enemyPos,
  input  logic [7:0]  enemyAttack,
  output logic [4:0]  unitDamageSelect,
  output logic [4:0]  enemyDamageSelect,
  output logic [11:0] totalUnitDamage,
  output logic [11:0] totalEnemyDamage,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIND  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  TOWER_SEL   = 5'b10000;
  localparam logic [9:0]  ET_TOWER    = 10'(ENEMY_TOWER_POS);
  localparam logic [9:0]  FT_TOWER    = 10'(FRIENDLY_TOWER_POS);
  localparam logic [10:0] U_RANGE_11  = 11'(UNIT_RANGE);
  localparam logic [10:0] E_RANGE_11  = 11'(ENEMY_RANGE);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;

  // Working target registers; select bit 4 set means "no live slot found yet".
  logic [4:0]  r_et_sel;
  logic [9:0]  r_et_pos;
  logic [4:0]  r_ft_sel;
  logic [9:0]  r_ft_pos;

  logic [11:0] r_u_acc;
  logic [11:0] r_e_acc;

  logic [4:0]  r_out_usel;
  logic [4:0]  r_out_esel;
  logic [11:0] r_out_utot;
  logic [11:0] r_out_etot;
  logic        r_done;

  logic        w_last;
  logic        w_enemy_better;
  logic        w_unit_better;
  logic [10:0] w_u_diff;
  logic [10:0] w_e_diff;
  logic        w_u_hit;
  logic        w_e_hit;
  logic [11:0] w_u_sum;
  logic [11:0] w_e_sum;

  assign w_last = (r_idx == 4'd15);

  // Strict compares keep the earlier (lower-index) slot on position ties.
  assign w_enemy_better = enemyAlive && (r_et_sel[4] || (enemyPos < r_et_pos));
  assign w_unit_better  = unitAlive  && (r_ft_sel[4] || (unitPos  > r_ft_pos));

  // 11-bit differences; the ordering guard rejects targets already passed.
  assign w_u_diff = {1'b0, r_et_pos} - {1'b0, unitPos};
  assign w_e_diff = {1'b0, enemyPos} - {1'b0, r_ft_pos};
  assign w_u_hit  = unitAlive  && (r_et_pos >= unitPos)  && (w_u_diff <= U_RANGE_11);
  assign w_e_hit  = enemyAlive && (enemyPos >= r_ft_pos) && (w_e_diff <= E_RANGE_11);
  assign w_u_sum  = r_u_acc + (w_u_hit ? {4'd0, unitAttack}  : 12'd0);
  assign w_e_sum  = r_e_acc + (w_e_hit ? {4'd0, enemyAttack} : 12'd0);

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_FIND;
      S_FIND: begin
        Busy = 1'b1;
        if (w_last) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        Busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_et_sel   <= TOWER_SEL;
      r_et_pos   <= ET_TOWER;
      r_ft_sel   <= TOWER_SEL;
      r_ft_pos   <= FT_TOWER;
      r_u_acc    <= 12'd0;
      r_e_acc    <= 12'd0;
      r_out_usel <= TOWER_SEL;
      r_out_esel <= TOWER_SEL;
      r_out_utot <= 12'd0;
      r_out_etot <= 12'd0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= 4'd0;
          if (Start) begin
            r_et_sel <= TOWER_SEL;
            r_et_pos <= ET_TOWER;
            r_ft_sel <= TOWER_SEL;
            r_ft_pos <= FT_TOWER;
            r_u_acc  <= 12'd0;
            r_e_acc  <= 12'd0;
          end
        end
        S_FIND: begin
          if (w_enemy_better) begin
            r_et_sel <= {1'b0, r_idx};
            r_et_pos <= enemyPos;
          end
          if (w_unit_better) begin
            r_ft_sel <= {1'b0, r_idx};
            r_ft_pos <= unitPos;
          end
          // Wraps 15 -> 0 so ACCUM starts at slot 0.
          r_idx <= r_idx + 4'd1;
        end
        S_ACCUM: begin
          r_u_acc <= w_u_sum;
          r_e_acc <= w_e_sum;
          r_idx   <= r_idx + 4'd1;
          if (w_last) begin
            // Slot 15's contribution is folded in directly on the DONE-entry edge.
            r_out_esel <= r_et_sel;
            r_out_usel <= r_ft_sel;
            r_out_utot <= w_u_sum;
            r_out_etot <= w_e_sum;
            r_done     <= 1'b1;
          end
        end
        S_DONE:  r_idx <= 4'd0;
        default: r_idx <= 4'd0;
      endcase
    end
  end

  assign scanIndex         = r_idx;
  assign unitDamageSelect  = r_out_usel;
  assign enemyDamageSelect = r_out_esel;
  assign totalUnitDamage   = r_out_utot;
  assign totalEnemyDamage  = r_out_etot;
  assign Done              = r_done;

endmodule
